// File: rtl/dco_arbiter.sv
// Round-robin arbiter that lends one DCO to NREQ requesters for a counted burst of oscillator periods.
// Optional watchdog abort of stalled bursts is built when DCO_WATCHDOG_EN is defined.
module dco_arbiter #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int BW   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*W-1:0]  cfgMax,
    input  logic [NREQ*W-1:0]  cfgDuty,
    input  logic [NREQ*BW-1:0] cfgBurst,
    input  logic               osc,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [W-1:0]       maxVal,
    output logic [W-1:0]       duty,
    output logic               dcoReset,
    output logic               busy,
    output logic               err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]   RR_RESET = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   win_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [W-1:0]    max_val_q;
    logic [W-1:0]    duty_q;
    logic            dco_reset_q;
    logic            busy_q;
    logic [BW-1:0]   remain_q;
    logic            osc_d_q;

    logic [PW-1:0]   win_idx_s;
    logic [PW-1:0]   cand_s;
    logic            rise_s;

`ifdef DCO_WATCHDOG_EN
    localparam logic [W:0] WD_MAX = {(W+1){1'b1}};
    logic [W:0] wdog_q;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign maxVal   = max_val_q;
    assign duty     = duty_q;
    assign dcoReset = dco_reset_q;
    assign busy     = busy_q;
    assign rise_s   = osc & ~osc_d_q;

    // Round-robin pick: walk downward so the nearest requester after rr_ptr_q is assigned last and wins.
    always_comb begin
        win_idx_s = {PW{1'b0}};
        cand_s    = {PW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            cand_s    = PW'((int'(rr_ptr_q) + k) % NREQ);
            win_idx_s = req[cand_s] ? cand_s : win_idx_s;
        end
    end

    // Arbitration FSM; every output is a register updated together with the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            win_q       <= {PW{1'b0}};
            rr_ptr_q    <= RR_RESET;
            gnt_q       <= {NREQ{1'b0}};
            done_q      <= {NREQ{1'b0}};
            max_val_q   <= {W{1'b0}};
            duty_q      <= {W{1'b0}};
            dco_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            remain_q    <= {BW{1'b0}};
            osc_d_q     <= 1'b0;
`ifdef DCO_WATCHDOG_EN
            wdog_q      <= {(W+1){1'b0}};
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q      <= {NREQ{1'b0}};
                    dco_reset_q <= 1'b1;
`ifdef DCO_WATCHDOG_EN
                    err_q       <= 1'b0;
`endif
                    if (|req) begin
                        state_q   <= LOAD;
                        win_q     <= win_idx_s;
                        rr_ptr_q  <= win_idx_s;
                        gnt_q     <= ONE_HOT0 << win_idx_s;
                        busy_q    <= 1'b1;
                        max_val_q <= cfgMax[win_idx_s*W +: W];
                        duty_q    <= cfgDuty[win_idx_s*W +: W];
                        remain_q  <= cfgBurst[win_idx_s*BW +: BW];
                    end else begin
                        gnt_q  <= {NREQ{1'b0}};
                        busy_q <= 1'b0;
                    end
                end
                LOAD: begin
                    osc_d_q <= 1'b0;
`ifdef DCO_WATCHDOG_EN
                    wdog_q  <= {(W+1){1'b0}};
`endif
                    if (!req[win_q]) begin
                        state_q     <= IDLE;
                        gnt_q       <= {NREQ{1'b0}};
                        busy_q      <= 1'b0;
                        dco_reset_q <= 1'b1;
                    end else if (remain_q == {BW{1'b0}}) begin
                        state_q     <= DONE;
                        done_q      <= ONE_HOT0 << win_q;
                        gnt_q       <= {NREQ{1'b0}};
                        busy_q      <= 1'b0;
                        dco_reset_q <= 1'b1;
                    end else begin
                        state_q     <= RUN;
                        dco_reset_q <= 1'b0;
                    end
                end
                RUN: begin
                    osc_d_q <= osc;
                    // A dropped request wins over a coincident rise: the burst is abandoned.
                    if (!req[win_q]) begin
                        state_q     <= IDLE;
                        gnt_q       <= {NREQ{1'b0}};
                        busy_q      <= 1'b0;
                        dco_reset_q <= 1'b1;
                    end else if (rise_s) begin
                        remain_q <= remain_q - BW'(1);
`ifdef DCO_WATCHDOG_EN
                        wdog_q   <= {(W+1){1'b0}};
`endif
                        if (remain_q == BW'(1)) begin
                            state_q     <= DONE;
                            done_q      <= ONE_HOT0 << win_q;
                            gnt_q       <= {NREQ{1'b0}};
                            busy_q      <= 1'b0;
                            dco_reset_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
`ifdef DCO_WATCHDOG_EN
                    else if (wdog_q == WD_MAX) begin
                        state_q     <= IDLE;
                        err_q       <= 1'b1;
                        gnt_q       <= {NREQ{1'b0}};
                        busy_q      <= 1'b0;
                        dco_reset_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + {{W{1'b0}}, 1'b1};
                    end
`else
                    else begin
                        state_q <= RUN;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= {NREQ{1'b0}};
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= {NREQ{1'b0}};
                    done_q      <= {NREQ{1'b0}};
                    busy_q      <= 1'b0;
                    dco_reset_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dco_arbiter.sv
// Self-checking bench for dco_arbiter: directed corner cases, then random request rounds
// scored against a transaction-level round-robin model.
module tb_dco_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int BW   = 8;

    typedef struct {
        int idx;
        int mx;
        int dt;
        int bu;
    } rec_t;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NREQ-1:0]    req;
    logic [NREQ*W-1:0]  cfgMax;
    logic [NREQ*W-1:0]  cfgDuty;
    logic [NREQ*BW-1:0] cfgBurst;
    logic               osc = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [W-1:0]       maxVal;
    logic [W-1:0]       duty;
    logic               dcoReset;
    logic               busy;
    logic               err;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];
    bit   mon_en    = 1'b0;
    bit   dco_stuck = 1'b0;
    logic [W-1:0] dco_cnt = '0;

    dco_arbiter #(.W(W), .NREQ(NREQ), .BW(BW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .cfgMax(cfgMax), .cfgDuty(cfgDuty),
        .cfgBurst(cfgBurst), .osc(osc), .gnt(gnt), .done(done), .maxVal(maxVal),
        .duty(duty), .dcoReset(dcoReset), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Simple DCO: period maxVal+1 clocks, high while the phase counter is below duty.
    always @(posedge clk) begin
        if (dcoReset || dco_stuck) begin
            dco_cnt <= '0;
            osc     <= 1'b0;
        end else begin
            dco_cnt <= (dco_cnt >= maxVal) ? '0 : dco_cnt + 1'b1;
            osc     <= (dco_cnt < duty);
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endfunction

    // Monitor: pops an expected grant at each new grant, then counts osc rises to time the done pulse.
    int   m_cyc = 0;
    int   m_rises = 0;
    int   m_done_cyc = 0;
    bit   m_active = 0, m_in_load = 0, m_done_next = 0, m_gap_exp = 0, m_prev = 0;
    rec_t cur;
    always @(negedge clk) begin
        if (mon_en) begin
            m_cyc++;
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (m_done_next) begin
                chk("done_pulse", 32'(done), 32'd1 << cur.idx);
                chk("gnt_at_done", 32'(gnt), 32'd0);
                chk("dcoreset_at_done", 32'(dcoReset), 32'd1);
                req[cur.idx] = 1'b0;
                m_gap_exp    = (req != '0);
                m_done_cyc   = m_cyc;
                m_done_next  = 1'b0;
                m_active     = 1'b0;
            end else if (done != '0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end
            if (!m_active && gnt != '0) begin
                if (exp_q.size() == 0) begin
                    chk("grant_without_request", 32'(gnt), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_winner", 32'(gnt), 32'd1 << cur.idx);
                    chk("grant_maxval", 32'(maxVal), 32'(cur.mx));
                    chk("grant_duty", 32'(duty), 32'(cur.dt));
                    chk("load_dcoreset", 32'(dcoReset), 32'd1);
                    chk("load_busy", 32'(busy), 32'd1);
                    if (m_gap_exp) chk("done_to_grant_gap", 32'(m_cyc - m_done_cyc), 32'd2);
                    m_gap_exp = 1'b0;
                    // Config moves after latching must not affect the running burst.
                    cfgMax[cur.idx*W +: W]    = W'($urandom);
                    cfgDuty[cur.idx*W +: W]   = W'($urandom);
                    cfgBurst[cur.idx*BW +: BW] = BW'($urandom);
                    m_active = 1'b1;
                    m_prev   = 1'b0;
                    m_rises  = 0;
                    if (cur.bu == 0) begin
                        m_done_next = 1'b1;
                        m_in_load   = 1'b0;
                    end else begin
                        m_in_load = 1'b1;
                    end
                end
            end else if (m_active) begin
                if (m_in_load) begin
                    chk("run_dcoreset_low", 32'(dcoReset), 32'd0);
                    m_in_load = 1'b0;
                end
                chk("gnt_held", 32'(gnt), 32'd1 << cur.idx);
                chk("run_maxval_held", 32'(maxVal), 32'(cur.mx));
                if (osc && !m_prev) m_rises++;
                m_prev = osc;
                if (m_rises == cur.bu) m_done_next = 1'b1;
            end
        end
    end

    int mx_a[NREQ];
    int dt_a[NREQ];
    int bu_a[NREQ];

    initial begin
        int rr_m;
        int t;
        int rises;
        int run_cnt;
        bit prev;
        bit err_seen;
        logic [NREQ-1:0] mask;

        resetn = 1'b0; req = '0; cfgMax = '0; cfgDuty = '0; cfgBurst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dcoreset", 32'(dcoReset), 32'd1);
        chk("rst_maxval", 32'(maxVal), 32'd0);
        chk("rst_duty", 32'(duty), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Burst of 3 on requester 0, then a 2-cycle reset in the middle of RUN.
        cfgMax[0*W +: W] = 8'd4; cfgDuty[0*W +: W] = 8'd2; cfgBurst[0*BW +: BW] = 8'd3;
        req = 4'b0001;
        @(negedge clk);
        chk("first_grant_req0", 32'(gnt), 32'h1);
        chk("first_grant_dcoreset", 32'(dcoReset), 32'd1);
        chk("first_grant_maxval", 32'(maxVal), 32'd4);
        @(negedge clk);
        chk("run_after_load_dcoreset", 32'(dcoReset), 32'd0);
        chk("run_after_load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrun_rst_gnt", 32'(gnt), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_dcoreset", 32'(dcoReset), 32'd1);
        chk("midrun_rst_maxval", 32'(maxVal), 32'd0);
        chk("midrun_rst_duty", 32'(duty), 32'd0);
        chk("midrun_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        req = '0;
        resetn = 1'b1;
        @(negedge clk);

        // Requester 1 abandons a burst of 10 after two osc rises.
        cfgMax[1*W +: W] = 8'd4; cfgDuty[1*W +: W] = 8'd2; cfgBurst[1*BW +: BW] = 8'd10;
        req = 4'b0010;
        rises = 0; prev = 1'b0; t = 0;
        while (rises < 2 && t < 200) begin
            @(negedge clk);
            t++;
            if (gnt != '0 && !dcoReset) begin
                if (osc && !prev) rises++;
                prev = osc;
            end
        end
        chk("abort_rises_seen", 32'(rises), 32'd2);
        @(negedge clk);
        chk("abort_still_granted", 32'(gnt), 32'h2);
        req = '0;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dcoreset", 32'(dcoReset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort_no_late_done", 32'(done), 32'd0);

        // Oscillator stuck low during RUN.
        dco_stuck = 1'b1;
        cfgMax[2*W +: W] = 8'd4; cfgDuty[2*W +: W] = 8'd4; cfgBurst[2*BW +: BW] = 8'd5;
        req = 4'b0100;
`ifdef DCO_WATCHDOG_EN
        run_cnt = 0; t = 0;
        while (!err && t < 700) begin
            @(negedge clk);
            t++;
            if (gnt != '0 && !dcoReset) run_cnt++;
        end
        req = '0;
        chk("wdog_err_seen", 32'(err), 32'd1);
        chk("wdog_run_cycles", 32'(run_cnt), 32'd512);
        chk("wdog_gnt", 32'(gnt), 32'd0);
        chk("wdog_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("wdog_err_one_cycle", 32'(err), 32'd0);
`else
        err_seen = 1'b0;
        run_cnt = 0;
        repeat (600) begin
            @(negedge clk);
            err_seen = err_seen | err;
            if (gnt != '0 && !dcoReset) run_cnt++;
        end
        chk("stuck_busy", 32'(busy), 32'd1);
        chk("stuck_err", 32'(err_seen), 32'd0);
        chk("stuck_gnt", 32'(gnt), 32'h4);
        chk("stuck_run_cycles", 32'(run_cnt), 32'd599);
        req = '0;
`endif
        repeat (3) @(negedge clk);
        dco_stuck = 1'b0;

        // Random rounds: each round holds a request mask until every member has had its done pulse.
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rr_m = NREQ - 1;
        mon_en = 1'b1;
        for (int r = 0; r < 30; r++) begin
            mask = (r == 0) ? 4'hF : 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                mx_a[i] = $urandom_range(1, 7);
                dt_a[i] = $urandom_range(1, mx_a[i]);
                bu_a[i] = (r == 0) ? 1 : $urandom_range(0, 4);
                cfgMax[i*W +: W]    = W'(mx_a[i]);
                cfgDuty[i*W +: W]   = W'(dt_a[i]);
                cfgBurst[i*BW +: BW] = BW'(bu_a[i]);
            end
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (rr_m + k) % NREQ;
                if (mask[idx]) begin
                    exp_q.push_back('{idx, mx_a[idx], dt_a[idx], bu_a[idx]});
                end
            end
            for (int k = NREQ; k >= 1; k--) begin
                if (mask[(rr_m + k) % NREQ]) begin
                    rr_m = (rr_m + k) % NREQ;
                    break;
                end
            end
            req = mask;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(req == '0 && gnt == '0 && done == '0 && busy == 1'b0) && t < 3000);
            if (t >= 3000) begin
                chk("round_timeout", 32'(t), 32'd0);
                break;
            end
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dco_arbiter.md
DCO_ARBITER -- requirements
Module: dco_arbiter

Interface
REQ-001 SHALL have parameter W, default 8: DCO maxVal/duty width.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-003 SHALL have parameter BW, default 8: burst-count width.
REQ-004 SHALL have port clk  input  1: single clock, all logic on the rising edge.
REQ-005 SHALL have port resetn  input  1: reset is synchronous and active-low.
REQ-006 SHALL have port req  input  NREQ: per-requester request, level, held until done or abandoned.
REQ-007 SHALL have port cfgMax  input  NREQ*W: per-requester DCO maxVal; slice i is [i*W +: W].
REQ-008 SHALL have port cfgDuty  input  NREQ*W: per-requester DCO duty; same slicing as cfgMax.
REQ-009 SHALL have port cfgBurst  input  NREQ*BW: per-requester number of osc periods.
REQ-010 SHALL have port osc  input  1: DCO output fed back; clk-synchronous.
REQ-011 SHALL have port gnt  output  NREQ: one-hot grant, or all zero.
REQ-012 SHALL have port done  output  NREQ: one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port maxVal  output  W: drives DCO maxVal.
REQ-014 SHALL have port duty  output  W: drives DCO duty.
REQ-015 SHALL have port dcoReset  output  1: active-high reset to the DCO.
REQ-016 SHALL have port busy  output  1: high in LOAD and RUN.
REQ-017 SHALL have port err  output  1: one-cycle watchdog abort pulse.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-019 IDLE with any req high: the winner SHALL be chosen round-robin, searching from rrPtr+1 with wrap; next state LOAD.
REQ-020 On the IDLE->LOAD transition, the block SHALL latch the winner's cfgMax/cfgDuty into maxVal/duty and cfgBurst into the remaining counter, and set rrPtr to the winner; cfg changes after latching SHALL be ignored.
REQ-021 In LOAD, gnt[winner]=1, dcoReset=1 and the osc edge register is cleared; next state is RUN, or DONE if the latched burst=0.
REQ-022 In RUN, gnt[winner]=1 and dcoReset=0; rise = osc & ~osc_d; each rise SHALL decrement the remaining counter.
REQ-023 In RUN, a rise with remaining==1 SHALL go to DONE next cycle.
REQ-024 In DONE, done[winner]=1 for exactly one cycle, gnt=0 and dcoReset=1; next state IDLE.
REQ-025 Earliest next grant: the gnt for the next requester SHALL rise 2 cycles after its done pulse, because DONE->IDLE->LOAD.
REQ-026 req[winner] low in LOAD or RUN SHALL abort: next state IDLE, no done pulse, gnt=0, dcoReset=1.
REQ-027 Requests arriving in LOAD, RUN or DONE SHALL wait; they are never lost while held.
REQ-028 maxVal and duty SHALL hold their last latched values in IDLE and DONE.
REQ-029 In IDLE, dcoReset=1, gnt=0 and done=0.

Reset
REQ-030 resetn low at a clk edge SHALL force IDLE, including mid-burst.
REQ-031 Reset values: gnt=0, done=0, busy=0, err=0, dcoReset=1, maxVal=0, duty=0, remaining=0, osc_d=0, watchdog=0, rrPtr=NREQ-1 (so requester 0 wins first).

Configuration
REQ-032 With DCO_WATCHDOG_EN defined, a (W+1)-bit counter SHALL clear in LOAD and on each rise and increment in RUN.
REQ-033 With DCO_WATCHDOG_EN defined, the counter reaching 2^(W+1)-1 in RUN SHALL cause: err=1 for one cycle, no done, gnt=0, and next state IDLE.
REQ-034 Without DCO_WATCHDOG_EN, there SHALL be no watchdog logic, err SHALL be tied 0, and RUN waits indefinitely for rises.

Verification
REQ-035 resetn low 2 cycles mid-RUN -> next cycle: IDLE, gnt=0, busy=0, dcoReset=1, maxVal=0, duty=0, err=0.
REQ-036 req=0001, cfgMax=4, cfgDuty=2, cfgBurst=3, DCO model attached -> gnt[0] at t+1, dcoReset low from t+2, done[0] pulse one cycle after the third osc rise (about 15 clk).
REQ-037 req=1111 held, all cfgBurst=1 -> grant order 0,1,2,3,0; never two gnt bits high.
REQ-038 req=0100, cfgBurst=0 -> LOAD at t+1, done[2] at t+2, no RUN cycle, dcoReset never low.
REQ-039 req=0010, burst=10, req[1] dropped after 2 rises -> IDLE next cycle, done=0, dcoReset=1.
REQ-040 DCO_WATCHDOG_EN defined, cfgMax=cfgDuty=4 (osc stuck 0) -> err pulse after 512 RUN cycles, gnt=0; macro undefined -> busy stays 1, err=0.
